shim_integ_window_ctrl: RTL and testbench

SHIM_INTEG_WINDOW_CTRL -- requirements
Module: shim_integ_window_ctrl

---
 rtl/shim_integ_pkg.sv | 23 ++
 rtl/shim_integ_accum.sv | 33 +++
 rtl/shim_integ_window_ctrl.sv | 150 +++++++++++++++
 tb/tb_shim_integ_window_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/shim_integ_pkg.sv
// Shared types and sizing for the SPI-domain integration window controller.
package shim_integ_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARM   = 3'd1,
    ST_RUN   = 3'd2,
    ST_EVAL  = 3'd3,
    ST_FAULT = 3'd4
  } state_e;

  localparam int unsigned MIN_WINDOW_DEF = 16;
  localparam int unsigned SUM_W          = 48;
  localparam int unsigned LIMIT_W        = 47;
  localparam int unsigned WIN_W          = 32;
  localparam int unsigned THR_W          = 15;

  function automatic logic [WIN_W-1:0] clamp_window(input logic [WIN_W-1:0] req,
                                                    input logic [WIN_W-1:0] min_w);
    return (req < min_w) ? min_w : req;
  endfunction

endpackage

// File: rtl/shim_integ_accum.sv
// Saturating 48-bit magnitude accumulator; clear has priority over add.
module shim_integ_accum
  import shim_integ_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             clr_i,
  input  logic             add_i,
  input  logic [15:0]      operand_i,
  output logic [SUM_W-1:0] sum_o
);

  logic [SUM_W-1:0] sum_q, sum_d;
  logic [SUM_W:0]   sum_ext;

  always_comb begin
    sum_ext = {1'b0, sum_q} + (SUM_W+1)'(operand_i);
    sum_d   = sum_q;
    if (clr_i) begin
      sum_d = '0;
    end else if (add_i) begin
      sum_d = sum_ext[SUM_W] ? '1 : sum_ext[SUM_W-1:0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) sum_q <= '0;
    else          sum_q <= sum_d;
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/shim_integ_window_ctrl.sv
// Integration window controller: runs fixed-length windows of sample magnitude
// and compares the sum against thresh*window, latching a sticky fault on overrun.
//
// state | meaning
// IDLE  | waiting for spi_en && integ_en
// ARM   | latch window length, limit; clear sum
// RUN   | accumulate samples, count down window
// EVAL  | compare sum against limit
// FAULT | sticky over-threshold, held until spi_en drops
module shim_integ_window_ctrl
  import shim_integ_pkg::*;
#(
  parameter int unsigned MIN_WINDOW = MIN_WINDOW_DEF
) (
  input  logic        spi_clk,
  input  logic        spi_resetn,
  input  logic        spi_en,
  input  logic        integ_en,
  input  logic [31:0] integ_window,
  input  logic [14:0] integ_thresh_avg,
  input  logic        sample_valid,
  input  logic [15:0] sample_abs,
  output logic        integ_active,
  output logic        window_start,
  output logic        window_end,
  output logic        over_thresh,
  output logic [15:0] window_count,
  output logic [2:0]  state_dbg
);

  state_e             state_q, state_d;
  logic [WIN_W-1:0]   cnt_q, cnt_d;
  logic [LIMIT_W-1:0] limit_q, limit_d;
  logic               integ_active_q, integ_active_d;
  logic               window_start_q, window_start_d;
  logic               window_end_q, window_end_d;
  logic               over_thresh_q, over_thresh_d;
  logic [15:0]        window_count_q, window_count_d;

  logic [SUM_W-1:0]   sum_acc;
  logic               acc_clr, acc_add;
  logic               run_en;
  logic               pass;
  logic [WIN_W-1:0]   win_req;

  assign run_en  = spi_en && integ_en;
  assign win_req = clamp_window(integ_window, WIN_W'(MIN_WINDOW));
  // Equality passes, so only a strictly larger sum faults.
  assign pass    = (sum_acc <= {1'b0, limit_q});

  shim_integ_accum u_accum (
    .clk_i     (spi_clk),
    .rst_n_i   (spi_resetn),
    .clr_i     (acc_clr),
    .add_i     (acc_add),
    .operand_i (sample_abs),
    .sum_o     (sum_acc)
  );

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    limit_d        = limit_q;
    window_end_d   = 1'b0;
    window_count_d = window_count_q;
    over_thresh_d  = over_thresh_q;
    acc_clr        = 1'b0;
    acc_add        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (run_en) state_d = ST_ARM;
      end
      ST_ARM: begin
        acc_clr = 1'b1;
        if (!spi_en) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d   = win_req - 1'b1;
          limit_d = LIMIT_W'(integ_thresh_avg) * LIMIT_W'(win_req);
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!spi_en) begin
          acc_clr = 1'b1;
          state_d = ST_IDLE;
        end else begin
          acc_add = sample_valid;
          cnt_d   = cnt_q - 1'b1;
          if (cnt_q == '0) state_d = ST_EVAL;
        end
      end
      ST_EVAL: begin
        if (!spi_en) begin
          acc_clr = 1'b1;
          state_d = ST_IDLE;
        end else if (!pass) begin
          over_thresh_d = 1'b1;
          state_d       = ST_FAULT;
        end else begin
          window_end_d   = 1'b1;
          window_count_d = window_count_q + 16'd1;
          state_d        = run_en ? ST_ARM : ST_IDLE;
        end
      end
      ST_FAULT: begin
        if (!spi_en) begin
          acc_clr       = 1'b1;
          over_thresh_d = 1'b0;
          state_d       = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    integ_active_d = (state_d == ST_ARM) || (state_d == ST_RUN) || (state_d == ST_EVAL);
    window_start_d = (state_q == ST_ARM) && (state_d == ST_RUN);
  end

  always_ff @(posedge spi_clk or negedge spi_resetn) begin
    if (!spi_resetn) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      limit_q        <= '0;
      integ_active_q <= 1'b0;
      window_start_q <= 1'b0;
      window_end_q   <= 1'b0;
      over_thresh_q  <= 1'b0;
      window_count_q <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      limit_q        <= limit_d;
      integ_active_q <= integ_active_d;
      window_start_q <= window_start_d;
      window_end_q   <= window_end_d;
      over_thresh_q  <= over_thresh_d;
      window_count_q <= window_count_d;
    end
  end

  assign integ_active = integ_active_q;
  assign window_start = window_start_q;
  assign window_end   = window_end_q;
  assign over_thresh  = over_thresh_q;
  assign window_count = window_count_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_shim_integ_window_ctrl.sv
// Directed bench for shim_integ_window_ctrl with hand-computed expectations.
module tb_shim_integ_window_ctrl;

  logic        spi_clk = 1'b0;
  logic        spi_resetn;
  logic        spi_en;
  logic        integ_en;
  logic [31:0] integ_window;
  logic [14:0] integ_thresh_avg;
  logic        sample_valid;
  logic [15:0] sample_abs;
  logic        integ_active;
  logic        window_start;
  logic        window_end;
  logic        over_thresh;
  logic [15:0] window_count;
  logic [2:0]  state_dbg;

  localparam logic [2:0] S_IDLE = 3'd0, S_ARM = 3'd1, S_RUN = 3'd2, S_EVAL = 3'd3,
                         S_FAULT = 3'd4;

  int n_chk  = 0;
  int n_pass = 0;
  int len;
  int ws;
  logic [63:0] exp_lim;

  shim_integ_window_ctrl dut (
    .spi_clk          (spi_clk),
    .spi_resetn       (spi_resetn),
    .spi_en           (spi_en),
    .integ_en         (integ_en),
    .integ_window     (integ_window),
    .integ_thresh_avg (integ_thresh_avg),
    .sample_valid     (sample_valid),
    .sample_abs       (sample_abs),
    .integ_active     (integ_active),
    .window_start     (window_start),
    .window_end       (window_end),
    .over_thresh      (over_thresh),
    .window_count     (window_count),
    .state_dbg        (state_dbg)
  );

  always #5 spi_clk = ~spi_clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge spi_clk);
    #1;
  endtask

  // Walks to RUN, then counts RUN cycles; at RUN cycle mid_at the given inputs are applied.
  task automatic run_window(input int mid_at, input logic [31:0] mid_win, input logic mid_ien,
                            input logic mid_sen, output int n_run, output int n_ws);
    int n;
    n = 0;
    n_run = 0;
    n_ws = 0;
    while (state_dbg != S_RUN && n < 300) begin tick(); n++; end
    while (state_dbg == S_RUN && n < 300) begin
      n_run++;
      if (window_start) n_ws++;
      if (n_run == mid_at) begin
        integ_window = mid_win;
        integ_en     = mid_ien;
        spi_en       = mid_sen;
      end
      tick();
      n++;
    end
  endtask

  initial begin
    spi_resetn       = 1'b0;
    spi_en           = 1'b0;
    integ_en         = 1'b0;
    integ_window     = 32'd0;
    integ_thresh_avg = 15'd0;
    sample_valid     = 1'b0;
    sample_abs       = 16'd0;
    #12;
    chk("rst_state", state_dbg, S_IDLE);
    chk("rst_active", integ_active, 1'b0);
    chk("rst_count", window_count, 16'd0);
    chk("rst_over", over_thresh, 1'b0);
    @(negedge spi_clk);
    spi_resetn = 1'b1;
    tick();

    // Exact-limit window: 100 x 10 == 10 x 100 passes; valid in ARM/EVAL must be ignored.
    integ_window = 32'd100; integ_thresh_avg = 15'd10;
    sample_abs = 16'd10; sample_valid = 1'b1;
    spi_en = 1'b1; integ_en = 1'b1;
    tick();
    chk("a_arm_state", state_dbg, S_ARM);
    chk("a_arm_active", integ_active, 1'b1);
    run_window(-1, 32'd100, 1'b1, 1'b1, len, ws);
    chk("a_len", len, 100);
    chk("a_ws_pulses", ws, 1);
    chk("a_eval_state", state_dbg, S_EVAL);
    chk("a_eval_wend", window_end, 1'b0);
    tick();
    chk("a_wend", window_end, 1'b1);
    chk("a_count", window_count, 16'd1);
    chk("a_over", over_thresh, 1'b0);
    chk("a_rearm", state_dbg, S_ARM);
    spi_en = 1'b0;
    tick();
    chk("a_idle", state_dbg, S_IDLE);
    chk("a_wend_low", window_end, 1'b0);

    // Over-limit by one per cycle.
    sample_abs = 16'd11; spi_en = 1'b1;
    run_window(-1, 32'd100, 1'b1, 1'b1, len, ws);
    chk("b_len", len, 100);
    chk("b_eval_over", over_thresh, 1'b0);
    tick();
    chk("b_fault_state", state_dbg, S_FAULT);
    chk("b_over", over_thresh, 1'b1);
    chk("b_wend", window_end, 1'b0);
    chk("b_active", integ_active, 1'b0);
    tick(); tick(); tick();
    chk("b_fault_hold", state_dbg, S_FAULT);
    chk("b_count", window_count, 16'd1);
    spi_en = 1'b0;
    tick();
    chk("b_idle", state_dbg, S_IDLE);
    chk("b_over_clr", over_thresh, 1'b0);

    // Clamp: 3 and 0 both become 16.
    sample_abs = 16'd0; integ_window = 32'd3; spi_en = 1'b1;
    run_window(-1, 32'd3, 1'b1, 1'b1, len, ws);
    chk("c_len3", len, 16);
    tick();
    chk("c_wend3", window_end, 1'b1);
    chk("c_count3", window_count, 16'd2);
    integ_window = 32'd0;
    run_window(-1, 32'd0, 1'b1, 1'b1, len, ws);
    chk("c_len0", len, 16);
    tick();
    chk("c_count0", window_count, 16'd3);
    chk("c_state0", state_dbg, S_ARM);

    // spi_en dropped at RUN cycle 50 of 100.
    integ_window = 32'd100;
    run_window(50, 32'd100, 1'b1, 1'b0, len, ws);
    chk("d_len", len, 50);
    chk("d_idle", state_dbg, S_IDLE);
    chk("d_wend", window_end, 1'b0);
    chk("d_active", integ_active, 1'b0);
    chk("d_count", window_count, 16'd3);
    tick();
    chk("d_wend_after", window_end, 1'b0);

    // integ_en dropped and window changed mid-window: current window finishes at 20.
    integ_window = 32'd20; spi_en = 1'b1; integ_en = 1'b1;
    run_window(5, 32'd30, 1'b0, 1'b1, len, ws);
    chk("e_len20", len, 20);
    tick();
    chk("e_wend", window_end, 1'b1);
    chk("e_idle", state_dbg, S_IDLE);
    chk("e_count", window_count, 16'd4);
    integ_en = 1'b1;
    run_window(-1, 32'd30, 1'b1, 1'b1, len, ws);
    chk("e_len30", len, 30);
    tick();
    chk("e_count2", window_count, 16'd5);
    spi_en = 1'b0;
    tick();
    chk("e_idle2", state_dbg, S_IDLE);

    // Maximum window/threshold/magnitude, then reset mid-RUN.
    sample_abs = 16'hFFFF; integ_window = 32'hFFFF_FFFF; integ_thresh_avg = 15'h7FFF;
    spi_en = 1'b1;
    tick();
    chk("f_arm", state_dbg, S_ARM);
    tick();
    chk("f_run", state_dbg, S_RUN);
    chk("f_wstart", window_start, 1'b1);
    exp_lim = 64'h7FFF * 64'hFFFF_FFFF;
    chk("f_limit", dut.limit_q, exp_lim);
    for (int i = 0; i < 10; i++) tick();
    chk("f_sum", dut.sum_acc, 64'd655350);
    chk("f_still_run", state_dbg, S_RUN);
    chk("f_count_pre", window_count, 16'd5);
    spi_resetn = 1'b0;
    #1;
    chk("f_rst_state", state_dbg, S_IDLE);
    chk("f_rst_active", integ_active, 1'b0);
    chk("f_rst_ws", window_start, 1'b0);
    chk("f_rst_we", window_end, 1'b0);
    chk("f_rst_over", over_thresh, 1'b0);
    chk("f_rst_count", window_count, 16'd0);
    chk("f_rst_sum", dut.sum_acc, 64'd0);
    @(negedge spi_clk);
    spi_resetn = 1'b1;
    integ_en = 1'b0;
    tick(); tick(); tick();
    chk("f_wait_idle", state_dbg, S_IDLE);
    chk("f_wait_we", window_end, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
